fifo_rd_drain: RTL and testbench

//  Read-side consumer of the async FIFO, clocked in the read domain.
//  - Pops one word when the FIFO is non-empty and the downstream serial transmitter is free.
//  - Presents the word with a one-cycle valid strobe.
//  - Waits for the transmitter busy handshake to rise and then fall.
//  - Enforces a programmable inter-word gap.
//  - Sits between the FIFO outputs (rdata/rempty/rinc) and the UART-style TX block.

---
 rtl/fifo_rd_drain_if.sv | 30 +++
 rtl/fifo_rd_drain.sv | 133 +++++++++++++
 tb/tb_fifo_rd_drain.sv | 340 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_rd_drain_if.sv
// ============================================================================
// Module   : fifo_rd_drain_if
// Brief    : FIFO read-port and TX start/busy handshake bundle for fifo_rd_drain.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fifo_rd_drain_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] rdata;
  logic             rempty;
  logic             rinc;
  logic             tx_busy;
  logic [WIDTH-1:0] tx_data;
  logic             tx_valid;

  // master = the drain engine, slave = FIFO read port plus TX block
  modport master (
    input  rdata, rempty, tx_busy,
    output rinc, tx_data, tx_valid
  );

  modport slave (
    output rdata, rempty, tx_busy,
    input  rinc, tx_data, tx_valid
  );
endinterface

`default_nettype wire

// File: rtl/fifo_rd_drain.sv
// ============================================================================
// Module   : fifo_rd_drain
// Brief    : Read-domain FIFO drain: pops one word at a time into a serial TX
//            with a start strobe, busy handshake and programmable gap.
//            Optional macro FIFO_RD_CNT_EN adds a saturating tx_count output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_rd_drain #(
  parameter int WIDTH = 8,
  parameter int GAP   = 0
`ifdef FIFO_RD_CNT_EN
  ,
  parameter int CNT_W = 16
`endif
) (
  input  wire logic        rclk,
  input  wire logic        rrst_n,
  input  wire logic        en,
  output logic             idle,
`ifdef FIFO_RD_CNT_EN
  output logic [CNT_W-1:0] tx_count,
`endif
  fifo_rd_drain_if.master  bus
);

  localparam logic [2:0] C_IDLE      = 3'd0;
  localparam logic [2:0] C_POP       = 3'd1;
  localparam logic [2:0] C_WAIT_ACK  = 3'd2;
  localparam logic [2:0] C_WAIT_DONE = 3'd3;
  localparam logic [2:0] C_GAP_WAIT  = 3'd4;

  localparam bit         C_HAS_GAP  = (GAP > 0);
  localparam logic [7:0] C_GAP_LOAD = C_HAS_GAP ? 8'(GAP - 1) : 8'd0;

  logic [2:0]       r_state;
  logic [2:0]       w_next_state;
  logic [7:0]       r_gap_cnt;
  logic [WIDTH-1:0] r_tx_data;
  logic             w_start;
  logic             w_pop;
  logic             w_idle;

  assign w_start = en & ~bus.rempty & ~bus.tx_busy;

  // State register
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_state <= C_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      C_IDLE: begin
        if (w_start) begin
          w_next_state = C_POP;
        end
      end
      C_POP: begin
        w_next_state = C_WAIT_ACK;
      end
      C_WAIT_ACK: begin
        if (bus.tx_busy) begin
          w_next_state = C_WAIT_DONE;
        end
      end
      C_WAIT_DONE: begin
        if (!bus.tx_busy) begin
          w_next_state = C_HAS_GAP ? C_GAP_WAIT : C_IDLE;
        end
      end
      C_GAP_WAIT: begin
        if (r_gap_cnt == 8'd0) begin
          w_next_state = C_IDLE;
        end
      end
      default: begin
        w_next_state = C_IDLE;
      end
    endcase
  end

  // Moore outputs: decoded from the state register only
  always_comb begin
    w_pop  = (r_state == C_POP);
    w_idle = (r_state == C_IDLE);
  end

  // Word latch and gap counter; counter loads GAP-1 so GAP_WAIT lasts GAP cycles
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_tx_data <= '0;
      r_gap_cnt <= 8'd0;
    end else begin
      if ((r_state == C_IDLE) && w_start) begin
        r_tx_data <= bus.rdata;
      end
      if ((r_state == C_WAIT_DONE) && (w_next_state == C_GAP_WAIT)) begin
        r_gap_cnt <= C_GAP_LOAD;
      end else if ((r_state == C_GAP_WAIT) && (r_gap_cnt != 8'd0)) begin
        r_gap_cnt <= r_gap_cnt - 8'd1;
      end
    end
  end

  assign bus.rinc     = w_pop;
  assign bus.tx_valid = w_pop;
  assign bus.tx_data  = r_tx_data;
  assign idle         = w_idle;

`ifdef FIFO_RD_CNT_EN
  logic [CNT_W-1:0] r_tx_count;

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_tx_count <= '0;
    end else if ((r_state == C_POP) && (r_tx_count != {CNT_W{1'b1}})) begin
      r_tx_count <= r_tx_count + 1'b1;
    end
  end

  assign tx_count = r_tx_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fifo_rd_drain.sv
// ============================================================================
// Module   : tb_fifo_rd_drain
// Brief    : Self-checking bench for fifo_rd_drain: FIFO/TX models, scoreboard,
//            IDLE qualification table and multi-cycle corner sequences.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_rd_drain;

  localparam int GAP   = 2;
  localparam int ACK_D = 2;

  logic clk    = 1'b0;
  logic rrst_n = 1'b0;
  logic en     = 1'b0;
  logic idle;
  logic model_on = 1'b0;

  logic [7:0] m_rdata  = 8'h00;
  logic [7:0] v_rdata  = 8'h00;
  logic       m_rempty = 1'b1;
  logic       v_rempty = 1'b1;
  logic       m_busy   = 1'b0;
  logic       v_busy   = 1'b0;

  fifo_rd_drain_if #(.WIDTH(8)) bus ();

  assign bus.rdata   = model_on ? m_rdata  : v_rdata;
  assign bus.rempty  = model_on ? m_rempty : v_rempty;
  assign bus.tx_busy = model_on ? m_busy   : v_busy;

`ifdef FIFO_RD_CNT_EN
  logic [1:0] tx_count;
`endif

  fifo_rd_drain #(
    .WIDTH (8),
    .GAP   (GAP)
`ifdef FIFO_RD_CNT_EN
    ,
    .CNT_W (2)
`endif
  ) dut (
    .rclk     (clk),
    .rrst_n   (rrst_n),
    .en       (en),
    .idle     (idle),
`ifdef FIFO_RD_CNT_EN
    .tx_count (tx_count),
`endif
    .bus      (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic       rempty;
    logic       busy;
    logic [7:0] data;
    logic       exp_pop;
  } vec_t;

  int         n_tests  = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  int         rinc_cnt = 0;
  int         ack_cnt  = 0;
  int         busy_cnt = 0;
  int         busy_len = 10;
  int         fall_cyc = 0;
  bit         have_fall = 1'b0;
  bit         gap_chk   = 1'b0;
  bit         done      = 1'b0;
  logic [7:0] fq[$];
  logic [7:0] sb[$];
  logic [7:0] last_tx = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic refresh();
    m_rempty = (fq.size() == 0);
    m_rdata  = (fq.size() != 0) ? fq[0] : 8'h00;
  endtask

  task automatic push_word(input logic [7:0] w);
    fq.push_back(w);
    sb.push_back(w);
    refresh();
  endtask

  // Per-cycle monitor, scoreboard compare, FIFO model and TX busy model
  task automatic step();
    logic [7:0] exp;
    cyc++;
    if (!rrst_n) begin
      last_tx  = 8'h00;
      m_busy   = 1'b0;
      ack_cnt  = 0;
      busy_cnt = 0;
      return;
    end
    if (bus.tx_valid) begin
      chk("rinc_with_valid", {31'd0, bus.rinc}, 32'd1);
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_pop: got %0h expected no pop", bus.tx_data);
      end else begin
        exp = sb.pop_front();
        chk("tx_data", {24'd0, bus.tx_data}, {24'd0, exp});
      end
      last_tx = bus.tx_data;
      if (gap_chk && have_fall) chk("gap_cycles", cyc - fall_cyc, GAP + 2);
    end else begin
      chk("tx_data_hold", {24'd0, bus.tx_data}, {24'd0, last_tx});
    end
    if (bus.rinc) rinc_cnt++;
    if (model_on) begin
      if (bus.rinc) begin
        chk("rinc_nonempty", {31'd0, fq.size() != 0}, 32'd1);
        if (fq.size() != 0) void'(fq.pop_front());
      end
      refresh();
      if (bus.tx_valid) begin
        ack_cnt = ACK_D;
      end else if (ack_cnt > 0) begin
        ack_cnt--;
        if (ack_cnt == 0) begin
          m_busy   = 1'b1;
          busy_cnt = busy_len;
        end
      end else if (m_busy) begin
        busy_cnt--;
        if (busy_cnt == 0) begin
          m_busy    = 1'b0;
          fall_cyc  = cyc;
          have_fall = 1'b1;
        end
      end
    end
  endtask

  task automatic wait_done_word(input string name, input int max);
    int i;
    for (i = 0; i < max; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && fq.size() == 0 && idle && !bus.tx_busy) break;
    end
    chk(name, {31'd0, i < max}, 32'd1);
  endtask

  task automatic wait_busy(input string name, input logic lvl, input int max);
    int i;
    for (i = 0; i < max; i++) begin
      @(negedge clk);
      if (bus.tx_busy == lvl) break;
    end
    chk(name, {31'd0, i < max}, 32'd1);
  endtask

  // Manual completion of a word popped during the table phase
  task automatic finish_manual();
    int i;
    v_rempty = 1'b0;
    v_rdata  = 8'hEE;
    repeat (3) @(negedge clk);
    chk("wait_ack_hold", {30'd0, idle, bus.rinc}, 32'd0);
    v_busy = 1'b1;
    repeat (3) @(negedge clk);
    v_rempty = 1'b1;
    v_busy   = 1'b0;
    for (i = 0; i < GAP + 6; i++) begin
      @(negedge clk);
      if (idle) break;
    end
    chk("manual_return_idle", {31'd0, idle}, 32'd1);
  endtask

  task automatic run_tests();
    vec_t vt[8];
    int   r0;
    int   r1;

    vt[0] = '{1'b0, 1'b0, 1'b0, 8'h11, 1'b0};
    vt[1] = '{1'b1, 1'b1, 1'b0, 8'h12, 1'b0};
    vt[2] = '{1'b1, 1'b0, 1'b1, 8'h13, 1'b0};
    vt[3] = '{1'b1, 1'b0, 1'b0, 8'h3C, 1'b1};
    vt[4] = '{1'b0, 1'b1, 1'b1, 8'h14, 1'b0};
    vt[5] = '{1'b1, 1'b1, 1'b1, 8'h15, 1'b0};
    vt[6] = '{1'b0, 1'b0, 1'b1, 8'h16, 1'b0};
    vt[7] = '{1'b1, 1'b0, 1'b0, 8'hC3, 1'b1};

    // T1: reset held with a poppable FIFO and enable high
    rrst_n   = 1'b0;
    v_rempty = 1'b0;
    v_rdata  = 8'h77;
    en       = 1'b1;
    repeat (3) @(negedge clk);
    chk("t1_rinc", {31'd0, bus.rinc}, 32'd0);
    chk("t1_tx_valid", {31'd0, bus.tx_valid}, 32'd0);
    chk("t1_tx_data", {24'd0, bus.tx_data}, 32'd0);
    chk("t1_idle", {31'd0, idle}, 32'd1);
    v_rempty = 1'b1;
    en       = 1'b0;
    @(negedge clk);
    rrst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("t1_idle_after_release", {31'd0, idle}, 32'd1);

    // IDLE qualification table: only en & !rempty & !busy pops
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      en       = vt[i].en;
      v_rempty = vt[i].rempty;
      v_busy   = vt[i].busy;
      v_rdata  = vt[i].data;
      if (vt[i].exp_pop) sb.push_back(vt[i].data);
      @(negedge clk);
      chk("vec_rinc", {31'd0, bus.rinc}, {31'd0, vt[i].exp_pop});
      chk("vec_idle", {31'd0, idle}, {31'd0, ~vt[i].exp_pop});
      if (vt[i].exp_pop) finish_manual();
      en       = 1'b0;
      v_busy   = 1'b0;
      v_rempty = 1'b1;
    end

    // T2: single word, then a second word queued while TX is busy
    @(negedge clk);
    model_on = 1'b1;
    busy_len = 10;
    push_word(8'hA5);
    r0 = rinc_cnt;
    @(negedge clk);
    en = 1'b1;
    wait_busy("t2_busy_rise_timeout", 1'b1, 20);
    r1 = rinc_cnt;
    push_word(8'h5A);
    wait_busy("t2_busy_fall_timeout", 1'b0, 30);
    chk("t2_no_pop_while_busy", rinc_cnt - r1, 0);
    chk("t2_tx_data_held", {24'd0, bus.tx_data}, 32'hA5);
    wait_done_word("t2_done_timeout", 60);
    chk("t2_pops", rinc_cnt - r0, 2);

    // T3: burst of three with GAP idle cycles after every busy fall
    @(negedge clk);
    en        = 1'b0;
    busy_len  = 3;
    have_fall = 1'b0;
    gap_chk   = 1'b1;
    push_word(8'h11);
    push_word(8'h22);
    push_word(8'h33);
    @(negedge clk);
    r0 = rinc_cnt;
    en = 1'b1;
    wait_done_word("t3_done_timeout", 100);
    chk("t3_pops", rinc_cnt - r0, 3);
    gap_chk = 1'b0;

    // T4: enable dropped mid-word
    busy_len = 6;
    push_word(8'h44);
    push_word(8'h55);
    wait_busy("t4_busy_rise_timeout", 1'b1, 20);
    en = 1'b0;
    wait_busy("t4_busy_fall_timeout", 1'b0, 30);
    repeat (GAP + 3) @(negedge clk);
    r0 = rinc_cnt;
    repeat (20) @(negedge clk);
    chk("t4_no_pop", rinc_cnt - r0, 0);
    chk("t4_idle_hold", {31'd0, idle}, 32'd1);
    en = 1'b1;
    @(negedge clk);
    chk("t4_repop_latency", {31'd0, bus.tx_valid}, 32'd1);
    wait_done_word("t4_done_timeout", 60);

    // T5: reset pulse while TX is busy
    push_word(8'h66);
    wait_busy("t5_busy_rise_timeout", 1'b1, 20);
    @(negedge clk);
    rrst_n = 1'b0;
    #1;
    chk("t5_rinc", {31'd0, bus.rinc}, 32'd0);
    chk("t5_tx_valid", {31'd0, bus.tx_valid}, 32'd0);
    chk("t5_tx_data", {24'd0, bus.tx_data}, 32'd0);
    chk("t5_idle", {31'd0, idle}, 32'd1);
    @(negedge clk);
    push_word(8'h77);
    r0 = rinc_cnt;
    @(negedge clk);
    rrst_n = 1'b1;
    wait_done_word("t5_done_timeout", 60);
    chk("t5_fresh_pop", rinc_cnt - r0, 1);

`ifdef FIFO_RD_CNT_EN
    // T6: saturating forwarded-word counter
    @(negedge clk);
    rrst_n = 1'b0;
    @(negedge clk);
    chk("t6_cnt_reset", {30'd0, tx_count}, 32'd0);
    rrst_n   = 1'b1;
    busy_len = 2;
    for (int k = 1; k <= 5; k++) begin
      push_word(8'(8'h80 + k));
      wait_done_word("t6_done_timeout", 40);
      chk("t6_tx_count", {30'd0, tx_count}, (k > 3) ? 32'd3 : 32'(k));
    end
`endif

    chk("sb_empty", sb.size(), 0);
  endtask

  initial begin
    fork
      begin
        while (!done) begin
          @(negedge clk);
          step();
        end
      end
      begin
        run_tests();
        done = 1'b1;
      end
    join
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
